// File: rtl/warp_issue_requester_if.sv
// Signal bundle between the warp issue requester and its neighbours: the instruction
// buffers, the scoreboard, the warp arbiter and the operand-collect stage.
interface warp_issue_requester_if #(
    parameter int NUM_WARPS_PER_SM = 4,
    parameter int INSTR_WIDTH      = 32
);
    logic [NUM_WARPS_PER_SM-1:0]             ibValid;
    logic [NUM_WARPS_PER_SM*INSTR_WIDTH-1:0] ibInstr;
    logic [NUM_WARPS_PER_SM-1:0]             sbStall;
    logic [NUM_WARPS_PER_SM-1:0]             ibPop;
    logic [NUM_WARPS_PER_SM-1:0]             request;
    logic [NUM_WARPS_PER_SM-1:0]             grantOH;
    logic                                    issueValid;
    logic                                    issueReady;
    logic [NUM_WARPS_PER_SM-1:0]             issueWarpOH;
    logic [INSTR_WIDTH-1:0]                  issueInstr;
    logic                                    grantError;

    // The requester drives requests, pops and the issue register.
    modport master (
        input  ibValid, ibInstr, sbStall, grantOH, issueReady,
        output ibPop, request, issueValid, issueWarpOH, issueInstr, grantError
    );

    modport slave (
        output ibValid, ibInstr, sbStall, grantOH, issueReady,
        input  ibPop, request, issueValid, issueWarpOH, issueInstr, grantError
    );
endinterface

// File: rtl/warp_issue_requester.sv
// Requests issue slots from the warp arbiter, pops the granted warp's head instruction
// into a single-entry issue register, and flags malformed grants.
module warp_issue_requester #(
    parameter int NUM_WARPS_PER_SM = 4,
    parameter int INSTR_WIDTH      = 32,
    parameter int HOLDOFF          = 2
) (
    input logic                    clk,
    input logic                    reset,
    warp_issue_requester_if.master bus
);
    localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);

    logic [CNT_W-1:0]            holdCnt [NUM_WARPS_PER_SM];
    logic                        canAccept_p0;
    logic                        legal_p0;
    logic                        illegal_p0;
    logic [NUM_WARPS_PER_SM-1:0] request_p0;
    logic [INSTR_WIDTH-1:0]      popInstr_p0;

    function automatic logic is_one_hot(input logic [NUM_WARPS_PER_SM-1:0] v);
        return (v != '0) && ((v & (v - NUM_WARPS_PER_SM'(1))) == '0);
    endfunction

    // Stage p0: request, grant qualification and head-instruction select, all same cycle
    always_comb begin
        request_p0   = '0;
        popInstr_p0  = '0;
        canAccept_p0 = ~bus.issueValid | bus.issueReady;
        for (int i = 0; i < NUM_WARPS_PER_SM; i++) begin
            request_p0[i] = ~reset & canAccept_p0 & bus.ibValid[i] & ~bus.sbStall[i]
                            & (holdCnt[i] == '0);
            if (bus.grantOH[i])
                popInstr_p0 = popInstr_p0 | bus.ibInstr[i*INSTR_WIDTH +: INSTR_WIDTH];
        end
        // A grant to a warp that did not request would pop an instruction nobody asked for.
        legal_p0   = is_one_hot(bus.grantOH) && ((bus.grantOH & ~request_p0) == '0);
        illegal_p0 = (bus.grantOH != '0) && !legal_p0;
    end

    assign bus.request = request_p0;
    assign bus.ibPop   = legal_p0 ? bus.grantOH : '0;

    // Stage p1: issue register; a legal grant overwrites a draining entry without a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.issueValid  <= 1'b0;
            bus.issueWarpOH <= '0;
            bus.issueInstr  <= '0;
            bus.grantError  <= 1'b0;
        end else begin
            if (legal_p0) begin
                bus.issueValid  <= 1'b1;
                bus.issueWarpOH <= bus.grantOH;
                bus.issueInstr  <= popInstr_p0;
            end else if (bus.issueReady) begin
                bus.issueValid  <= 1'b0;
            end
            if (illegal_p0)
                bus.grantError <= 1'b1;
        end
    end

    // Per-warp holdoff: a fresh grant reloads, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WARPS_PER_SM; i++)
                holdCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WARPS_PER_SM; i++) begin
                if (legal_p0 && bus.grantOH[i])
                    holdCnt[i] <= HOLD_LOAD;
                else if (holdCnt[i] != '0)
                    holdCnt[i] <= holdCnt[i] - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_warp_issue_requester.sv
// Directed bench: HOLDOFF=2 instance for holdoff/backpressure/error/stall/reset,
// HOLDOFF=0 instance for back-to-back round-robin issue.
module tb_warp_issue_requester;
    localparam int NW = 4;
    localparam int IW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    warp_issue_requester_if #(.NUM_WARPS_PER_SM(NW), .INSTR_WIDTH(IW)) b0 ();
    warp_issue_requester_if #(.NUM_WARPS_PER_SM(NW), .INSTR_WIDTH(IW)) b1 ();

    warp_issue_requester #(.NUM_WARPS_PER_SM(NW), .INSTR_WIDTH(IW), .HOLDOFF(2)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.master));
    warp_issue_requester #(.NUM_WARPS_PER_SM(NW), .INSTR_WIDTH(IW), .HOLDOFF(0)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.master));

    int nAssert = 0;
    int nFail   = 0;

    logic [IW-1:0] inst0 [NW] = '{32'hA000_00A0, 32'hB111_00B1, 32'hC222_00C2, 32'hD333_00D3};
    logic [IW-1:0] inst1 [NW] = '{32'h1234_0001, 32'h2345_0002, 32'h3456_0003, 32'h4567_0004};

    // Round-robin arbiter model standing in for the real arbiter
    int unsigned ptr0 = 0;
    int unsigned ptr1 = 0;
    logic        force0;
    logic [NW-1:0] forceVal0;

    function automatic logic [NW-1:0] rr(input logic [NW-1:0] req, input int unsigned p);
        logic [NW-1:0] g;
        bit found;
        g = '0;
        found = 0;
        for (int k = 0; k < NW; k++) begin
            int unsigned idx;
            idx = (p + k) % NW;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found = 1;
            end
        end
        return g;
    endfunction

    function automatic int unsigned next_ptr(input logic [NW-1:0] g);
        int unsigned n;
        n = 0;
        for (int k = 0; k < NW; k++)
            if (g[k]) n = (k + 1) % NW;
        return n;
    endfunction

    always_comb b0.grantOH = force0 ? forceVal0 : rr(b0.request, ptr0);
    always_comb b1.grantOH = rr(b1.request, ptr1);

    always @(posedge clk) begin
        if (!force0 && b0.grantOH != '0) ptr0 <= next_ptr(b0.grantOH);
        if (b1.grantOH != '0) ptr1 <= next_ptr(b1.grantOH);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        force0         = 1'b0;
        forceVal0      = '0;
        b0.ibValid     = '0;
        b0.sbStall     = '0;
        b0.issueReady  = 1'b1;
        b1.ibValid     = '0;
        b1.sbStall     = '0;
        b1.issueReady  = 1'b1;
        for (int i = 0; i < NW; i++) begin
            b0.ibInstr[i*IW +: IW] = inst0[i];
            b1.ibInstr[i*IW +: IW] = inst1[i];
        end
        #1 reset = 1'b1;
        tick();

        // Reset state
        chk("rst_valid",  64'(b0.issueValid),  0);
        chk("rst_warp",   64'(b0.issueWarpOH), 0);
        chk("rst_instr",  64'(b0.issueInstr),  0);
        chk("rst_err",    64'(b0.grantError),  0);
        b0.ibValid = 4'b1111;
        settle();
        chk("rst_req",    64'(b0.request), 0);
        chk("rst_pop",    64'(b0.ibPop),   0);
        b0.ibValid = '0;
        reset = 1'b0;

        // Single warp with HOLDOFF=2
        b0.ibValid = 4'b0001;
        settle();
        chk("hold_req_t",   64'(b0.request), 4'b0001);
        chk("hold_pop_t",   64'(b0.ibPop),   4'b0001);
        tick();
        chk("hold_valid_t1", 64'(b0.issueValid),  1);
        chk("hold_warp_t1",  64'(b0.issueWarpOH), 4'b0001);
        chk("hold_instr_t1", 64'(b0.issueInstr),  inst0[0]);
        chk("hold_req_t1",   64'(b0.request),     0);
        tick();
        chk("hold_req_t2",   64'(b0.request),     0);
        chk("hold_valid_t2", 64'(b0.issueValid),  0);
        chk("hold_instr_t2", 64'(b0.issueInstr),  inst0[0]);
        tick();
        chk("hold_req_t3",   64'(b0.request),     4'b0001);
        b0.ibValid = '0;
        settle();
        tick();

        // Backpressure, then drain and refill in the same cycle
        b0.ibValid    = 4'b0100;
        b0.issueReady = 1'b0;
        settle();
        chk("bp_req0", 64'(b0.request), 4'b0100);
        chk("bp_pop0", 64'(b0.ibPop),   4'b0100);
        tick();
        b0.ibValid = 4'b1000;
        settle();
        for (int c = 0; c < 5; c++) begin
            chk("bp_req",   64'(b0.request),     0);
            chk("bp_pop",   64'(b0.ibPop),       0);
            chk("bp_valid", 64'(b0.issueValid),  1);
            chk("bp_warp",  64'(b0.issueWarpOH), 4'b0100);
            chk("bp_instr", 64'(b0.issueInstr),  inst0[2]);
            tick();
        end
        b0.issueReady = 1'b1;
        settle();
        chk("bp_req_rel", 64'(b0.request), 4'b1000);
        chk("bp_pop_rel", 64'(b0.ibPop),   4'b1000);
        tick();
        chk("bp_valid_new", 64'(b0.issueValid),  1);
        chk("bp_warp_new",  64'(b0.issueWarpOH), 4'b1000);
        chk("bp_instr_new", 64'(b0.issueInstr),  inst0[3]);
        b0.ibValid = '0;
        tick();
        chk("bp_drain",  64'(b0.issueValid), 0);
        chk("err_clean", 64'(b0.grantError), 0);

        // Malformed grants: multi-hot, then a grant to a non-requesting warp
        b0.ibValid = 4'b0010;
        force0     = 1'b1;
        forceVal0  = 4'b0110;
        settle();
        chk("bad_req",  64'(b0.request), 4'b0010);
        chk("bad_pop0", 64'(b0.ibPop),   0);
        tick();
        chk("bad_err0",   64'(b0.grantError), 1);
        chk("bad_valid0", 64'(b0.issueValid), 0);
        forceVal0 = 4'b0001;
        settle();
        chk("bad_pop1", 64'(b0.ibPop), 0);
        tick();
        chk("bad_err1",   64'(b0.grantError), 1);
        chk("bad_valid1", 64'(b0.issueValid), 0);
        b0.ibValid = '0;
        force0     = 1'b0;
        forceVal0  = '0;
        repeat (10) tick();
        chk("bad_err_sticky", 64'(b0.grantError), 1);

        // Scoreboard stall on warp 0
        b0.ibValid = 4'b0011;
        b0.sbStall = 4'b0001;
        settle();
        chk("sb_req0", 64'(b0.request), 4'b0010);
        chk("sb_pop0", 64'(b0.ibPop),   4'b0010);
        tick();
        chk("sb_warp0",  64'(b0.issueWarpOH), 4'b0010);
        chk("sb_instr0", 64'(b0.issueInstr),  inst0[1]);
        chk("sb_req1",   64'(b0.request),     0);
        b0.sbStall = '0;
        settle();
        chk("sb_req2", 64'(b0.request), 4'b0001);
        chk("sb_pop2", 64'(b0.ibPop),   4'b0001);
        tick();
        chk("sb_valid3", 64'(b0.issueValid),  1);
        chk("sb_warp3",  64'(b0.issueWarpOH), 4'b0001);
        chk("sb_instr3", 64'(b0.issueInstr),  inst0[0]);

        // Asynchronous reset with a held instruction and a live holdoff counter
        b0.issueReady = 1'b0;
        b0.ibValid    = '0;
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(b0.issueValid),  0);
        chk("ar_warp",  64'(b0.issueWarpOH), 0);
        chk("ar_instr", 64'(b0.issueInstr),  0);
        chk("ar_err",   64'(b0.grantError),  0);
        b0.ibValid    = 4'b1111;
        b0.issueReady = 1'b1;
        settle();
        chk("ar_req", 64'(b0.request), 0);
        chk("ar_pop", 64'(b0.ibPop),   0);
        tick();
        chk("ar_pop_edge",   64'(b0.ibPop),      0);
        chk("ar_valid_edge", 64'(b0.issueValid), 0);
        b0.ibValid = 4'b0001;
        reset = 1'b0;
        settle();
        chk("ar_hold_clear", 64'(b0.request), 4'b0001);
        b0.ibValid = '0;
        settle();
        tick();

        // HOLDOFF=0: all warps valid, back-to-back round-robin issue
        b1.ibValid = 4'b1111;
        settle();
        for (int k = 0; k < NW; k++) begin
            chk("rr_req", 64'(b1.request), 4'b1111);
            chk("rr_pop", 64'(b1.ibPop),   64'(1) << k);
            tick();
            chk("rr_valid", 64'(b1.issueValid),  1);
            chk("rr_warp",  64'(b1.issueWarpOH), 64'(1) << k);
            chk("rr_instr", 64'(b1.issueInstr),  inst1[k]);
        end
        b1.ibValid = '0;
        tick();
        chk("rr_drain", 64'(b1.issueValid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
